// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation,
// common to the receive and transmit sides.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
      return clk_freq_hz / baud_rate;
   endfunction

   function automatic int half_bit(input int clk_freq_hz, input int baud_rate);
      return clks_per_bit(clk_freq_hz, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; the head reads as zero while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a small receive FIFO and sticky
// overrun / framing-error flags.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; push on high, framing error on low
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       overrun,
   output logic       frame_err,
   input  logic       err_clr
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int HALF_BIT     = half_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

   uart_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             rx_s1, rx_s2, rx_s3;
   logic             fall;
   logic             push_req;
   logic             frame_set;
   logic             ovr_set;
   logic             fifo_full;
   logic             fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign fall = rx_s3 && !rx_s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      push_req    = 1'b0;
      frame_set   = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               cnt_nxt   = HALF_LOAD;
            end
         end
         START: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (rx_s2) begin
               state_nxt = IDLE;
            end else begin
               state_nxt   = DATA;
               cnt_nxt     = BIT_LOAD;
               bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               shift_nxt = {rx_s2, shift[7:1]};
               cnt_nxt   = BIT_LOAD;
               if (bit_idx == 3'd7)
                  state_nxt = STOP;
               else
                  bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = IDLE;
               if (rx_s2)
                  push_req = 1'b1;
               else
                  frame_set = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A same-cycle pop makes room, so only an unserviced full FIFO loses the byte.
   assign ovr_set = push_req && fifo_full && !rd_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovr_set)
            overrun <= 1'b1;
         else if (err_clr)
            overrun <= 1'b0;
         if (frame_set)
            frame_err <= 1'b1;
         else if (err_clr)
            frame_err <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (shift_nxt),
      .pop       (rd_en),
      .pop_data  (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are issued
// and a negedge monitor checks every byte popped by rd_en.
module tb_uart_rx;

   localparam int CPB = 104;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       rx      = 1'b1;
   logic       rd_en   = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       overrun;
   logic       frame_err;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];

   uart_rx dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .overrun   (overrun),
      .frame_err (frame_err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rd_en && rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got %0h want no byte", rd_data);
         end else begin
            chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rx = stop_bit;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic pop_one();
      int t;
      t = 0;
      @(negedge clk);
      while (!rd_valid && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!rd_valid) begin
         checks++;
         failures++;
         $display("FAIL pop_wait: rd_valid got 0 want 1 within 2000 cycles");
      end else begin
         @(posedge clk);
         #1 rd_en = 1'b1;
         @(posedge clk);
         #1 rd_en = 1'b0;
      end
   endtask

   task automatic pulse_err_clr();
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      logic [7:0] fill_bytes [4];
      fill_bytes[0] = 8'hA0; fill_bytes[1] = 8'hA1;
      fill_bytes[2] = 8'hA2; fill_bytes[3] = 8'hA3;

      #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      idle_cycles(3);
      reset = 1'b0;
      idle_cycles(10);

      // single frame, latency from rx falling edge to rd_valid
      exp_q.push_back(8'h55);
      lat = 0;
      fork
         send_byte(8'h55, 1'b1);
         begin
            @(posedge clk);
            #1;
            while (!rd_valid && lat < 1200) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      checks++;
      if (lat < 987 || lat > 993) begin
         failures++;
         $display("FAIL latency: got %0d want 987..993", lat);
      end
      chk("valid_data_55", int'(rd_data), 8'h55);
      pop_one();
      @(negedge clk);
      chk("drop_after_pop", int'(rd_valid), 0);
      chk("data_zero_empty", int'(rd_data), 0);

      // rd_en on empty FIFO must be ignored
      #1 rd_en = 1'b1;
      idle_cycles(3);
      rd_en = 1'b0;
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      pop_one();
      @(negedge clk);
      chk("empty_pop_ignored", int'(rd_valid), 0);

      // overrun: five frames, no reads
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      idle_cycles(10);
      chk("overrun_set", int'(overrun), 1);
      chk("overrun_no_ferr", int'(frame_err), 0);
      for (int i = 0; i < 4; i++) pop_one();
      @(negedge clk);
      chk("overrun_drained", int'(rd_valid), 0);
      pulse_err_clr();
      @(negedge clk);
      chk("overrun_cleared", int'(overrun), 0);

      // framing error, then line held low
      send_byte(8'hA3, 1'b0);
      idle_cycles(5);
      chk("ferr_set", int'(frame_err), 1);
      chk("ferr_no_push", int'(rd_valid), 0);
      idle_cycles(100);
      pulse_err_clr();
      idle_cycles(1900);
      chk("ferr_no_retrigger", int'(frame_err), 0);
      rx = 1'b1;
      idle_cycles(1200);
      chk("ferr_hold_no_push", int'(rd_valid), 0);
      chk("ferr_hold_no_ovr", int'(overrun), 0);

      // 40-cycle glitch
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (40) @(posedge clk);
      #1 rx = 1'b1;
      idle_cycles(1200);
      chk("glitch_no_push", int'(rd_valid), 0);
      chk("glitch_no_ferr", int'(frame_err), 0);
      chk("glitch_no_ovr", int'(overrun), 0);
      exp_q.push_back(8'h96);
      send_byte(8'h96, 1'b1);
      pop_one();

      // reset during 4th data bit of 0xFF
      fork
         send_byte(8'hFF, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (CPB * 4 + 50) @(posedge clk);
            #1 reset = 1'b1;
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
         end
      join
      idle_cycles(200);
      chk("midrst_no_push", int'(rd_valid), 0);
      chk("midrst_no_ferr", int'(frame_err), 0);
      chk("midrst_no_ovr", int'(overrun), 0);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      pop_one();

      // full FIFO, pop coincides with the stop-bit push
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(fill_bytes[i]);
         send_byte(fill_bytes[i], 1'b1);
      end
      idle_cycles(5);
      chk("full_valid", int'(rd_valid), 1);
      exp_q.push_back(8'hA4);
      fork
         send_byte(8'hA4, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (990) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
         end
      join
      chk("coincide_no_ovr", int'(overrun), 0);
      for (int i = 0; i < 4; i++) pop_one();
      @(negedge clk);
      chk("coincide_drained", int'(rd_valid), 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 12000000, the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, the serial bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, the receive FIFO entries; it is a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1 format, idle high.
REQ-007 The block SHALL have port rd_en, input, 1 bit: CPU load strobe that pops one FIFO byte.
REQ-008 The block SHALL have port rd_data, output, 8 bits: FIFO head byte, first-word fall-through.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: FIFO non-empty.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, a byte was dropped because the FIFO was full.
REQ-011 The block SHALL have port frame_err, output, 1 bit: sticky flag, a stop bit sampled low.
REQ-012 The block SHALL have port err_clr, input, 1 bit: clears both sticky flags.

Function
REQ-013 The block SHALL pass rx through a two-flop synchronizer and one further edge-detect flop; a falling edge is a 1-to-0 transition between the last two flops.
REQ-014 The block SHALL derive CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division, 104 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (52).
REQ-015 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
- IDLE: on a falling edge, load the counter and go to START.
REQ-016 START SHALL sample the line HALF_BIT cycles after entry.
- Low: go to DATA.
- High (glitch): go to IDLE; no flags change.
REQ-017 DATA SHALL sample every CLKS_PER_BIT cycles.
- Bits shift in LSB first.
- After the 8th sample, go to STOP.
REQ-018 STOP SHALL sample once, CLKS_PER_BIT cycles after the last data sample.
- High: push the byte.
- Low: set frame_err, drop the byte.
- Either way, return to IDLE in the same cycle.
REQ-019 From IDLE, a new frame SHALL start only on a falling edge, so a line held low after a framing error does not retrigger reception.
REQ-020 A push into a full FIFO SHALL drop the byte and set overrun, unless rd_en is asserted in the same cycle; in that case both pop and push occur and overrun is not set.
REQ-021 rd_en while the FIFO is empty SHALL be ignored, with no pointer or count change.
REQ-022 A push and a pop in the same cycle on a non-empty FIFO SHALL leave the count unchanged.
REQ-023 rd_valid SHALL rise the cycle after a push into an empty FIFO, and fall the cycle after the pop of the last entry.
REQ-024 rd_data SHALL be 8'h00 whenever rd_valid is low.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-026 err_clr SHALL clear overrun and frame_err on the next edge; a set event in the same cycle wins over err_clr.

Reset
REQ-027 Reset SHALL asynchronously force:
- FSM to IDLE;
- counters, bit index and shift register to 0;
- all synchronizer and edge-detect flops to 1 (line idle);
- FIFO pointers and count to 0;
- rd_valid, overrun and frame_err to 0, and rd_data to 8'h00.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without pushing data or setting flags; after release, reception resumes on the next falling edge.

Structure
REQ-029 The FSM state encoding and the CLKS_PER_BIT/HALF_BIT derivation SHALL live in a shared package, uart_pkg, which the transmit side also uses.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with push/pop/full/empty ports.
REQ-031 Estimated size SHALL be 150-250 lines of RTL in total.

Verification
REQ-032 Frame 0x55 at defaults: rd_valid SHALL rise 990 +/- 3 cycles after the rx falling edge, with rd_data = 0x55; rd_en then drops rd_valid the next cycle.
REQ-033 Frames 0x01, 0x02, 0x03, 0x04, 0x05 sent with no reads: the first four SHALL read back in order; 0x05 is dropped and overrun = 1.
REQ-034 Frame 0xA3 with stop bit low: frame_err = 1, rd_valid stays 0; rx then held low for 2000 cycles: no new frame starts; err_clr pulse: frame_err = 0.
REQ-035 40-cycle low glitch on idle rx: the FSM SHALL return to IDLE, with no push and no flags.
REQ-036 Reset asserted during the 4th data bit of frame 0xFF: rd_valid = 0 and no flags; a following frame 0x3C SHALL be received correctly.
REQ-037 FIFO full, with rd_en coinciding with the stop-bit push: count stays 4, overrun stays 0, and the new byte is read last.
